// File: rtl/video_timing.sv
// Raster timing generator: pixel clock enable, column/line counters, sync and
// blank decodes, a one-clock vblank interrupt and a 16-bit frame counter.
module video_timing #(
  parameter int CE_DIV  = 4,
  parameter int HACTIVE = 320,
  parameter int HFP     = 16,
  parameter int HSW     = 32,
  parameter int HBP     = 48,
  parameter int VACTIVE = 240,
  parameter int VFP     = 4,
  parameter int VSW     = 4,
  parameter int VBP     = 14
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ce_pix,
  output logic [8:0]  hcnt,
  output logic [8:0]  vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        vblank_irq,
  output logic [15:0] frame
);

  localparam int HTOTAL = HACTIVE + HFP + HSW + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSW + VBP;

  localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);
  localparam logic [8:0] H_LAST   = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(VTOTAL - 1);
  localparam logic [8:0] H_ACT    = 9'(HACTIVE);
  localparam logic [8:0] V_ACT    = 9'(VACTIVE);
  localparam logic [8:0] H_SYNC_S = 9'(HACTIVE + HFP);
  localparam logic [8:0] H_SYNC_E = 9'(HACTIVE + HFP + HSW);
  localparam logic [8:0] V_SYNC_S = 9'(VACTIVE + VFP);
  localparam logic [8:0] V_SYNC_E = 9'(VACTIVE + VFP + VSW);
  localparam logic [8:0] V_PRE    = 9'(VACTIVE - 1);

  logic [3:0]  div_reg;
  logic [8:0]  hcnt_reg;
  logic [8:0]  vcnt_reg;
  logic        irq_reg;
  logic [15:0] frame_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg   <= '0;
      hcnt_reg  <= '0;
      vcnt_reg  <= '0;
      irq_reg   <= 1'b0;
      frame_reg <= '0;
    end else begin
      irq_reg <= 1'b0;
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        if (hcnt_reg == H_LAST) begin
          hcnt_reg <= '0;
          vcnt_reg <= (vcnt_reg == V_LAST) ? 9'd0 : vcnt_reg + 9'd1;
          // The edge that moves onto the first blank line raises the pulse.
          if (vcnt_reg == V_PRE) begin
            irq_reg   <= 1'b1;
            frame_reg <= frame_reg + 16'd1;
          end
        end else begin
          hcnt_reg <= hcnt_reg + 9'd1;
        end
      end else begin
        div_reg <= div_reg + 4'd1;
      end
    end
  end

  // Pure decodes of state registers; reset values of the counters make them all low.
  assign ce_pix     = (div_reg == DIV_LAST);
  assign hcnt       = hcnt_reg;
  assign vcnt       = vcnt_reg;
  assign hblank     = (hcnt_reg >= H_ACT);
  assign vblank     = (vcnt_reg >= V_ACT);
  assign hsync      = (hcnt_reg >= H_SYNC_S) && (hcnt_reg < H_SYNC_E);
  assign vsync      = (vcnt_reg >= V_SYNC_S) && (vcnt_reg < V_SYNC_E);
  assign vblank_irq = irq_reg;
  assign frame      = frame_reg;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-size instance for line timing and a
// shrunken instance so full frames, interrupts and frame wrap fit a short run.
module tb_video_timing;

  localparam int BCD = 3, BHA = 8, BHFP = 2, BHSW = 3, BHBP = 3;
  localparam int BVA = 6, BVFP = 1, BVSW = 2, BVBP = 2;
  localparam int BFRAME = (BHA + BHFP + BHSW + BHBP) * (BVA + BVFP + BVSW + BVBP) * BCD;

  typedef struct packed {
    logic        ce;
    logic [8:0]  h;
    logic [8:0]  v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        irq;
    logic [15:0] fr;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic        ce_a, hs_a, vs_a, hb_a, vb_a, irq_a;
  logic [8:0]  hcnt_a, vcnt_a;
  logic [15:0] fr_a;
  logic        ce_b, hs_b, vs_b, hb_b, vb_b, irq_b;
  logic [8:0]  hcnt_b, vcnt_b;
  logic [15:0] fr_b;

  video_timing dut_a (
    .clk(clk), .reset(rst_a), .ce_pix(ce_a), .hcnt(hcnt_a), .vcnt(vcnt_a),
    .hsync(hs_a), .vsync(vs_a), .hblank(hb_a), .vblank(vb_a),
    .vblank_irq(irq_a), .frame(fr_a)
  );

  video_timing #(
    .CE_DIV(BCD), .HACTIVE(BHA), .HFP(BHFP), .HSW(BHSW), .HBP(BHBP),
    .VACTIVE(BVA), .VFP(BVFP), .VSW(BVSW), .VBP(BVBP)
  ) dut_b (
    .clk(clk), .reset(rst_b), .ce_pix(ce_b), .hcnt(hcnt_b), .vcnt(vcnt_b),
    .hsync(hs_b), .vsync(vs_b), .hblank(hb_b), .vblank(vb_b),
    .vblank_irq(irq_b), .frame(fr_b)
  );

  int errors = 0;
  int checks = 0;
  int ta = 0;
  int tb_t = 0;
  logic [15:0] off_b = 16'h0000;

  // Clock cycles elapsed since reset was last released.
  always @(posedge clk) begin
    ta   <= rst_a ? 0 : ta + 1;
    tb_t <= rst_b ? 0 : tb_t + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", nm, act, act, want, want, $time);
    end
  endtask

  // Raster position derived directly from elapsed time.
  function automatic obs_t model(input int t, input int cd, input int ha, input int hfp,
                                 input int hsw, input int hbp, input int va, input int vfp,
                                 input int vsw, input int vbp, input logic [15:0] off);
    obs_t o;
    int ht, vt, p, h, v, ft, entry, frames;
    ht     = ha + hfp + hsw + hbp;
    vt     = va + vfp + vsw + vbp;
    ft     = ht * vt;
    entry  = va * ht;
    p      = t / cd;
    h      = p % ht;
    v      = (p / ht) % vt;
    frames = (p < entry) ? 0 : (p - entry) / ft + 1;
    o.ce   = ((t % cd) == cd - 1);
    o.h    = 9'(h);
    o.v    = 9'(v);
    o.hb   = (h >= ha);
    o.vb   = (v >= va);
    o.hs   = (h >= ha + hfp) && (h < ha + hfp + hsw);
    o.vs   = (v >= va + vfp) && (v < va + vfp + vsw);
    o.irq  = ((t % cd) == 0) && ((p % ft) == entry);
    o.fr   = 16'(frames) + off;
    return o;
  endfunction

  task automatic chk_obs(input string nm, input obs_t a, input obs_t e);
    chk({nm, ".ce_pix"},     32'(a.ce),  32'(e.ce));
    chk({nm, ".hcnt"},       32'(a.h),   32'(e.h));
    chk({nm, ".vcnt"},       32'(a.v),   32'(e.v));
    chk({nm, ".hsync"},      32'(a.hs),  32'(e.hs));
    chk({nm, ".vsync"},      32'(a.vs),  32'(e.vs));
    chk({nm, ".hblank"},     32'(a.hb),  32'(e.hb));
    chk({nm, ".vblank"},     32'(a.vb),  32'(e.vb));
    chk({nm, ".vblank_irq"}, 32'(a.irq), 32'(e.irq));
    chk({nm, ".frame"},      32'(a.fr),  32'(e.fr));
  endtask

  always @(negedge clk) begin : compare
    obs_t ea, aa, eb, ab;
    aa = {ce_a, hcnt_a, vcnt_a, hs_a, vs_a, hb_a, vb_a, irq_a, fr_a};
    ab = {ce_b, hcnt_b, vcnt_b, hs_b, vs_b, hb_b, vb_b, irq_b, fr_b};
    ea = rst_a ? '0 : model(ta, 4, 320, 16, 32, 48, 240, 4, 4, 14, 16'h0000);
    eb = rst_b ? '0 : model(tb_t, BCD, BHA, BHFP, BHSW, BHBP, BVA, BVFP, BVSW, BVBP, off_b);
    chk_obs("cyc_a", aa, ea);
    chk_obs("cyc_b", ab, eb);
  end

  initial begin
    int n, hs_n, hs_first, hs_last, hb_rise, irq_n;
    logic prev_hb;

    repeat (3) @(posedge clk);
    #3;
    chk("rst_a_hcnt", 32'(hcnt_a), 0);
    chk("rst_a_vcnt", 32'(vcnt_a), 0);
    chk("rst_a_flags", 32'({ce_a, hs_a, vs_a, hb_a, vb_a, irq_a}), 0);
    chk("rst_a_frame", 32'(fr_a), 0);
    @(posedge clk);
    #2 rst_a = 1'b0; rst_b = 1'b0;

    // ce_pix in cycles 3 and 7; hcnt becomes 1 after the 4th edge.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("a_first_ce", 32'(ce_a), (c % 4 == 3) ? 1 : 0);
      chk("a_first_hcnt", 32'(hcnt_a), (c >= 4) ? 1 : 0);
    end

    n = 0;
    while (hcnt_a != 9'd415 && n < 3000) begin @(negedge clk); n++; end
    chk("a_reach_415", 32'(hcnt_a), 415);
    n = 0;
    while (hcnt_a != 9'd0 && n < 10) begin @(negedge clk); n++; end
    chk("a_wrap_hcnt", 32'(hcnt_a), 0);
    chk("a_wrap_vcnt", 32'(vcnt_a), 1);

    // Scan line 1 once per pixel.
    hs_n = 0; hs_first = -1; hs_last = -1; hb_rise = -1; prev_hb = hb_a;
    n = 0;
    while (vcnt_a == 9'd1 && n < 2000) begin
      if (ce_a) begin
        if (hs_a) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(hcnt_a);
          hs_last = int'(hcnt_a);
        end
        if (hb_a && !prev_hb) hb_rise = int'(hcnt_a);
        prev_hb = hb_a;
      end
      @(negedge clk);
      n++;
    end
    chk("a_hsync_width", 32'(hs_n), 32);
    chk("a_hsync_first", 32'(hs_first), 336);
    chk("a_hsync_last", 32'(hs_last), 367);
    chk("a_hblank_rise", 32'(hb_rise), 320);
    chk("a_line2_hcnt", 32'(hcnt_a), 0);
    chk("a_line2_hblank", 32'(hb_a), 0);

    // Async reset of B mid-line inside hsync/vsync/blank.
    n = 0;
    while (!(vcnt_b == 9'd7 && hcnt_b == 9'd11) && n < 2 * BFRAME) begin @(negedge clk); n++; end
    chk("b_pre_rst_flags", 32'({hs_b, vs_b, hb_b, vb_b}), 32'hF);
    #1 rst_b = 1'b1;
    #1;
    chk("b_async_hcnt", 32'(hcnt_b), 0);
    chk("b_async_vcnt", 32'(vcnt_b), 0);
    chk("b_async_flags", 32'({ce_b, hs_b, vs_b, hb_b, vb_b, irq_b}), 0);
    chk("b_async_frame", 32'(fr_b), 0);
    @(posedge clk);
    #2 rst_b = 1'b0;

    // Three frames: one 1-clk pulse per frame, frame counts 1,2,3.
    irq_n = 0;
    for (int c = 0; c < 3 * BFRAME + 20; c++) begin
      @(negedge clk);
      if (irq_b) begin
        irq_n++;
        chk("b_irq_time", 32'(tb_t), 32'(288 + (irq_n - 1) * 528));
        chk("b_irq_vcnt", 32'(vcnt_b), 6);
        chk("b_irq_hcnt", 32'(hcnt_b), 0);
        chk("b_irq_frame", 32'(fr_b), 32'(irq_n));
      end
    end
    chk("b_irq_count", 32'(irq_n), 3);

    // Reset during the pulse cycle kills it.
    n = 0;
    while (!irq_b && n < BFRAME + 10) begin @(negedge clk); n++; end
    chk("b_irq_seen", 32'(irq_b), 1);
    #1 rst_b = 1'b1;
    #1;
    chk("b_irq_rst_irq", 32'(irq_b), 0);
    chk("b_irq_rst_frame", 32'(fr_b), 0);
    @(posedge clk);
    #2 rst_b = 1'b0;

    // Frame counter wrap.
    repeat (100) @(negedge clk);
    #1;
    force dut_b.frame_reg = 16'hFFFF;
    off_b = 16'hFFFF;
    @(negedge clk);
    chk("b_forced_frame", 32'(fr_b), 32'hFFFF);
    #1 release dut_b.frame_reg;
    n = 0;
    while (!irq_b && n < BFRAME + 10) begin @(negedge clk); n++; end
    chk("b_wrap_irq", 32'(irq_b), 1);
    chk("b_wrap_frame", 32'(fr_b), 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CE_DIV, 4: clk cycles per pixel, legal range 2..16.
- HACTIVE, 320: visible pixels per line.
- HFP, 16: horizontal front porch, pixels.
- HSW, 32: hsync width, pixels.
- HBP, 48: horizontal back porch, pixels.
- VACTIVE, 240: visible lines per frame.
- VFP, 4: vertical front porch, lines.
- VSW, 4: vsync width, lines.
- VBP, 14: vertical back porch, lines.
- Derived totals: HTOTAL=HACTIVE+HFP+HSW+HBP (default 416); VTOTAL=VACTIVE+VFP+VSW+VBP (default 262); both SHALL be <=512.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ce_pix, out, 1: pixel clock enable.
- hcnt, out, 9: pixel column, 0..HTOTAL-1.
- vcnt, out, 9: line, 0..VTOTAL-1.
- hsync, out, 1: horizontal sync, active-high.
- vsync, out, 1: vertical sync, active-high.
- hblank, out, 1: outside visible columns.
- vblank, out, 1: outside visible lines.
- vblank_irq, out, 1: one-clk pulse at vblank entry.
- frame, out, 16: frame counter.

Function
REQ-003 Internal divider div SHALL increment every clk and wrap from CE_DIV-1 to 0.
REQ-004 ce_pix SHALL be high exactly in cycles where div==CE_DIV-1, i.e. one clk in every CE_DIV.
REQ-005 hcnt/vcnt SHALL change only on the clk edge ending a ce_pix-high cycle; at all other edges they hold.
REQ-006 On such an edge, hcnt SHALL increment; at hcnt==HTOTAL-1 it SHALL wrap to 0 and vcnt SHALL advance at the same edge.
REQ-007 vcnt SHALL wrap from VTOTAL-1 to 0 when hcnt also wraps; vcnt and hcnt never take out-of-range values.
REQ-008 hblank SHALL equal (hcnt>=HACTIVE), vblank SHALL equal (vcnt>=VACTIVE), zero-cycle aligned with the hcnt/vcnt values of the same cycle.
REQ-009 hsync SHALL be high iff HACTIVE+HFP <= hcnt < HACTIVE+HFP+HSW, same-cycle aligned.
REQ-010 vsync SHALL be high iff VACTIVE+VFP <= vcnt < VACTIVE+VFP+VSW, same-cycle aligned; it therefore changes only when hcnt==0.
REQ-011 vblank_irq SHALL pulse for exactly one clk: the first cycle in which vcnt==VACTIVE and hcnt==0 (the cycle after the transition edge).
REQ-012 vblank_irq SHALL NOT repeat during the remaining CE_DIV-1 cycles, or for the rest of that pixel.
REQ-013 frame SHALL increment by 1 (mod 65536) on the same edge that raises vblank_irq; it wraps 0xFFFF->0x0000 silently.
REQ-014 hcnt[2:0]/vcnt[2:0] SHALL be the in-cell pixel/row, and hcnt[8:3]/vcnt[8:3] the character cell, for direct use by the character-map stage.
REQ-015 All outputs SHALL be glitch-free register outputs or decodes of registers only; no combinational path from any input to any output.

Reset
REQ-016 reset SHALL act asynchronously; while high: div=0, hcnt=0, vcnt=0, frame=0, ce_pix=0, hsync=0, vsync=0, hblank=0, vblank=0, vblank_irq=0.
REQ-017 After reset deasserts, the first ce_pix SHALL occur in the CE_DIV-th clk cycle (div==CE_DIV-1).
REQ-018 Reset asserted mid-line or mid-frame SHALL immediately restore REQ-016 values; no pending vblank_irq survives reset.

Verification
REQ-019 Defaults, release reset -> ce_pix high in cycles 3,7,11...; hcnt reaches 1 after the 4th edge; hcnt=415->0 with vcnt+1.
REQ-020 Run one line -> hblank rises at hcnt=320; hsync high for hcnt 336..367 (32 pixels); hblank falls at hcnt=0.
REQ-021 Run full frame -> vblank rises at vcnt=240, vsync high for vcnt 244..247, vcnt wraps 261->0, frame length 416*262*4 clks.
REQ-022 Run 3 frames -> exactly 3 vblank_irq pulses, each 1 clk wide, at vcnt=240/hcnt=0; frame=1,2,3.
REQ-023 Assert reset asynchronously at vcnt=100/hcnt=200 between clk edges -> all outputs zero before next edge; timing restarts per REQ-017.
REQ-024 Force frame to 0xFFFF via run length -> next vblank entry gives frame=0x0000 with irq pulse.
